lu_hist_reader: RTL and testbench
=================================

Name: lu_hist_reader

Overview:
- Readout (drain) engine for the 256 x 16-bit counter memory that the increment pipeline writes.
- On a start pulse it sweeps every address in ascending order through one port of the dual-port synchronous memory.
- It presents each (address, count) pair on a valid/ready output stream.
- When requested, it zeroes each entry after that entry has been accepted.

Parameters:
- ADDR_W, 8, memory address width; the sweep covers 0 .. 2^ADDR_W-1.
- DATA_W, 16, counter/data width.
- SKIP_ZERO, 0, when 1 entries reading 0 are not emitted on the stream (they are still cleared if clear is enabled).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a sweep; honoured only in IDLE.
- clear_en  in  1  sampled with start; 1 = zero each entry after its beat is accepted.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse after the final address is processed.
- mem_addr  out  ADDR_W  address to the memory port.
- mem_rd  in  DATA_W  memory read data; valid the cycle after mem_addr is registered.
- mem_wd  out  DATA_W  write data to the memory port; constant 0.
- mem_we  out  1  memory write enable.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_addr  out  ADDR_W  address of the current beat.
- out_data  out  DATA_W  count of the current beat.
- out_last  out  1  beat is for address 2^ADDR_W-1.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, clear_q=0.
- Reset values of outputs: busy, done, mem_we, out_valid and out_last are 0; mem_addr, out_addr and out_data are 0.
- Reset mid-sweep aborts immediately. Memory contents are left as-is; entries may be partially cleared. No done pulse is produced.
- Memory timing: the memory registers mem_addr on the clk edge. mem_rd = mem[registered addr] combinationally, i.e. 1-cycle read latency. A write with mem_we=1 takes effect at the edge.
- FSM states and transitions:
  - IDLE: start=1 -> idx<=0, clear_q<=clear_en, go to ADDR.
  - ADDR: mem_addr=idx, mem_we=0 -> DATA.
  - DATA: capture mem_rd into out_data, idx into out_addr, and (idx==max) into out_last. If SKIP_ZERO=1 and mem_rd==0 -> CLR; else -> OUT.
  - OUT: out_valid=1, and out_addr/out_data/out_last are held stable until out_ready=1. Handshake at that edge -> CLR. out_valid must not drop without a handshake.
  - CLR: mem_addr=idx, mem_we=clear_q, mem_wd=0. If idx==max -> DONE; else idx<=idx+1 -> ADDR.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in every state except IDLE.
- start asserted while busy is ignored, with no queuing. clear_en is only sampled with an accepted start.
- idx wraps never: the sweep ends at idx==max, and idx returns to 0 only on the next start.
- out_ready may be high before out_valid. The beat is transferred only in OUT with both high.
- Back-to-back throughput: 4 cycles per emitted entry with out_ready held 1; 3 cycles per skipped entry.
  - Full sweep, no skips, out_ready=1: start accepted at cycle 0, done pulses at cycle 1+4*256 = 1025.
- If SKIP_ZERO=1 and entry max reads 0, no beat carries out_last. done still pulses.
- Read-before-clear ordering is guaranteed per entry: the clear write occurs only after the entry's beat is accepted (or skipped).
- Concurrent writes from the other memory port during a sweep are not arbitrated here. The data returned is whatever the memory holds at read time.

Test Plan:
- Memory preloaded mem[i]=i+1, clear_en=0, out_ready=1, start -> 256 beats (addr i, data i+1). out_last only on addr 255. done at cycle 1025. Memory unchanged.
- Same preload, clear_en=1 -> identical stream. Afterwards all 256 entries read 0. mem_we pulses 256 times, each after the matching handshake.
- Backpressure: out_ready toggled 0,0,1 repeating -> each beat held stable for 3 OUT cycles. No beat lost or duplicated. Total cycles = 1+256*6.
- SKIP_ZERO=1, only mem[3]=7 and mem[200]=65535 nonzero, clear_en=1 -> exactly 2 beats: (3,7) and (200,65535). out_last never asserted. done pulses. Memory all zero afterwards.
- start pulsed again at addr 100 mid-sweep -> ignored. The sweep completes normally with a single done.
- rst_n asserted during OUT at addr 50 with clear_en=1 -> all outputs are 0 within the reset cycle. Entries 0..49 are 0 and 50..255 are untouched. A subsequent start restarts the sweep at addr 0.

Source files
------------

// File: rtl/lu_hist_reader.sv
// Drain engine for the histogram counter memory. It sweeps every address in
// ascending order, streams each (address, count) pair and can clear entries once they are consumed.
module lu_hist_reader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_OUT,
    S_CLR,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic              clear_q;
  logic              idx_max;
  logic [ADDR_W-1:0] beat_addr_p1;
  logic [DATA_W-1:0] beat_data_p1;
  logic              beat_last_p1;

  assign idx_max = &idx;

  // Control: state, sweep index and the clear mode latched with start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      clear_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        idx     <= '0;
        clear_q <= clear_en;
      end else if (state == S_CLR && !idx_max) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Read data arrives one cycle after the address; capture the beat here so it
  // stays stable for as long as the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_addr_p1 <= '0;
      beat_data_p1 <= '0;
      beat_last_p1 <= 1'b0;
    end else if (state == S_DATA) begin
      beat_addr_p1 <= idx;
      beat_data_p1 <= mem_rd;
      beat_last_p1 <= idx_max;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_DATA;
      S_DATA: begin
        if (SKIP_ZERO != 0 && mem_rd == '0) state_nxt = S_CLR;
        else                                state_nxt = S_OUT;
      end
      S_OUT:  if (out_ready) state_nxt = S_CLR;
      S_CLR:  state_nxt = idx_max ? S_DONE : S_ADDR;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The clear write reuses the read address, so an entry is only zeroed after
  // its beat has left (or was skipped)
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign mem_addr  = idx;
  assign mem_wd    = '0;
  assign mem_we    = (state == S_CLR) && clear_q;
  assign out_valid = (state == S_OUT);
  assign out_addr  = beat_addr_p1;
  assign out_data  = beat_data_p1;
  assign out_last  = beat_last_p1 && (state == S_OUT);

endmodule

// File: tb/tb_lu_hist_reader.sv
// Scoreboard bench for lu_hist_reader: two instances (SKIP_ZERO 0 and 1), each
// with its own 1-cycle-latency memory model; expected beats are queued by the stimulus.
module tb_lu_hist_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear_en, out_ready;
  logic        sel;
  logic        load;
  int          load_pat;

  logic        start_a, busy_a, done_a, mem_we_a, out_valid_a, out_last_a;
  logic [7:0]  mem_addr_a, out_addr_a, raddr_a;
  logic [15:0] mem_rd_a, mem_wd_a, out_data_a;
  logic        start_b, busy_b, done_b, mem_we_b, out_valid_b, out_last_b;
  logic [7:0]  mem_addr_b, out_addr_b, raddr_b;
  logic [15:0] mem_rd_b, mem_wd_b, out_data_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  int          checks = 0;
  int          failures = 0;
  int          we_cnt = 0;
  int          last_seen = 0;
  logic [24:0] exp_q [$];

  always #5 clk = ~clk;

  assign start_a = start && !sel;
  assign start_b = start && sel;

  lu_hist_reader #(.ADDR_W(8), .DATA_W(16), .SKIP_ZERO(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .clear_en(clear_en),
    .busy(busy_a), .done(done_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
    .mem_wd(mem_wd_a), .mem_we(mem_we_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_addr(out_addr_a), .out_data(out_data_a),
    .out_last(out_last_a)
  );

  lu_hist_reader #(.ADDR_W(8), .DATA_W(16), .SKIP_ZERO(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .clear_en(clear_en),
    .busy(busy_b), .done(done_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_wd(mem_wd_b), .mem_we(mem_we_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_addr(out_addr_b), .out_data(out_data_b),
    .out_last(out_last_b)
  );

  function automatic logic [15:0] pat_val(input int p, input int i);
    logic [15:0] v;
    v = 16'h0;
    case (p)
      0: v = 16'(i + 1);
      1: v = (i == 3) ? 16'd7 : ((i == 200) ? 16'hFFFF : 16'h0);
      3: v = (i < 50) ? 16'h0 : 16'(i + 1);
      default: v = 16'h0;
    endcase
    return v;
  endfunction

  // Memory models: address registered at the edge, combinational read
  always @(posedge clk) begin
    raddr_a <= mem_addr_a;
    if (load && !sel) begin
      for (int i = 0; i < 256; i++) mem_a[i[7:0]] <= pat_val(load_pat, i);
    end else if (mem_we_a) begin
      mem_a[mem_addr_a] <= mem_wd_a;
    end
  end

  always @(posedge clk) begin
    raddr_b <= mem_addr_b;
    if (load && sel) begin
      for (int i = 0; i < 256; i++) mem_b[i[7:0]] <= pat_val(load_pat, i);
    end else if (mem_we_b) begin
      mem_b[mem_addr_b] <= mem_wd_b;
    end
  end

  assign mem_rd_a = mem_a[raddr_a];
  assign mem_rd_b = mem_b[raddr_b];

  wire        mv  = sel ? out_valid_b : out_valid_a;
  wire [7:0]  ma  = sel ? out_addr_b  : out_addr_a;
  wire [15:0] md  = sel ? out_data_b  : out_data_a;
  wire        ml  = sel ? out_last_b  : out_last_a;
  wire        mdn = sel ? done_b      : done_a;
  wire        mbs = sel ? busy_b      : busy_a;
  wire        mwe = sel ? mem_we_b    : mem_we_a;
  wire [7:0]  mad = sel ? mem_addr_b  : mem_addr_a;

  // Monitor: pops on every handshake, checks beat stability while stalled
  initial begin
    logic        pv, phs;
    logic [24:0] pbeat, e;
    pv = 1'b0; phs = 1'b0; pbeat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; phs = 1'b0;
      end else begin
        if (!sel && mem_we_a) begin
          we_cnt++;
          checks++;
          if (!phs) begin
            failures++;
            $display("FAIL we_order addr=%0d: write without preceding handshake, required handshake first", mem_addr_a);
          end
        end
        if (pv && !phs) begin
          checks++;
          if (!mv || {ma, md, ml} != pbeat) begin
            failures++;
            $display("FAIL hold: got valid=%0b beat=%h, required valid=1 beat=%h", mv, {ma, md, ml}, pbeat);
          end
        end
        if (mv && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_extra: got addr=%0d data=%0d last=%0b, required no beat", ma, md, ml);
          end else begin
            e = exp_q.pop_front();
            if ({ma, md, ml} != e) begin
              failures++;
              $display("FAIL beat: got addr=%0d data=%0d last=%0b, required addr=%0d data=%0d last=%0b",
                       ma, md, ml, e[24:17], e[16:1], e[0]);
            end
          end
        end
        if (ml) last_seen++;
        pv = mv; phs = mv && out_ready; pbeat = {ma, md, ml};
      end
    end
  end

  task automatic preload(input bit s, input int p);
    sel = s; load_pat = p; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic push_stream(input int p);
    for (int i = 0; i < 256; i++)
      exp_q.push_back({i[7:0], pat_val(p, i), (i == 255) ? 1'b1 : 1'b0});
  endtask

  task automatic check_mem(input string nm, input bit s, input int p);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 256; i++) begin
      if ((s ? mem_b[i[7:0]] : mem_a[i[7:0]]) != pat_val(p, i)) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d entries wrong (first addr %0d), required 0 wrong", nm, bad, first);
    end
  endtask

  task automatic check_outputs_zero(input string nm);
    checks++;
    if ({mbs, mdn, mwe, mv, ml} != 5'b0 || mad != 8'h0 || ma != 8'h0 || md != 16'h0) begin
      failures++;
      $display("FAIL %s: got busy=%0b done=%0b we=%0b valid=%0b last=%0b maddr=%0d oaddr=%0d data=%0d, required all 0",
               nm, mbs, mdn, mwe, mv, ml, mad, ma, md);
    end
  endtask

  task automatic check_eq(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", nm, got, want);
    end
  endtask

  task automatic run_sweep(input bit s, input bit clr, input bit bp, input bit restart, input int exp_cyc);
    int c, dn;
    bit got, pulsed;
    sel = s; clear_en = clr; out_ready = bp ? 1'b0 : 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("busy_after_start", int'(mbs), 1);
    got = 1'b0; pulsed = 1'b0;
    for (int k = 1; k <= 3000 && !got; k++) begin
      @(posedge clk); #1;
      c = k + 1;
      if (bp) out_ready = (c % 3 == 2);
      start = 1'b0;
      if (restart && !pulsed && mv && ma == 8'd100) begin
        start = 1'b1; pulsed = 1'b1;
      end
      if (mdn) begin
        got = 1'b1;
        check_eq("done_cycle", c, exp_cyc);
      end
    end
    start = 1'b0; out_ready = 1'b1;
    if (!got) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done in 3000 cycles, required done at %0d", exp_cyc);
    end
    dn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mdn || mbs) dn++;
    end
    check_eq("idle_after_done", dn, 0);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b0; clear_en = 1'b0; out_ready = 1'b0;
    sel = 1'b0; load = 1'b0; load_pat = 0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_a");
    sel = 1'b1;
    #1 check_outputs_zero("reset_b");
    sel = 1'b0;
    rst_n = 1'b1;

    // Plain sweep, no clear
    preload(1'b0, 0);
    push_stream(0);
    we_cnt = 0;
    run_sweep(1'b0, 1'b0, 1'b0, 1'b0, 1025);
    check_eq("we_count_noclear", we_cnt, 0);
    check_mem("mem_unchanged", 1'b0, 0);

    // Same stream with clear
    push_stream(0);
    we_cnt = 0;
    run_sweep(1'b0, 1'b1, 1'b0, 1'b0, 1025);
    check_eq("we_count_clear", we_cnt, 256);
    check_mem("mem_cleared", 1'b0, 2);

    // Backpressure 0,0,1
    preload(1'b0, 0);
    push_stream(0);
    run_sweep(1'b0, 1'b0, 1'b1, 1'b0, 1 + 256 * 6);

    // Zero skipping with clear
    preload(1'b1, 1);
    exp_q.push_back({8'd3, 16'd7, 1'b0});
    exp_q.push_back({8'd200, 16'hFFFF, 1'b0});
    last_seen = 0;
    run_sweep(1'b1, 1'b1, 1'b0, 1'b0, 1 + 254 * 3 + 2 * 4);
    check_eq("skip_no_last", last_seen, 0);
    check_mem("skip_mem_cleared", 1'b1, 2);

    // Start pulsed mid-sweep is ignored
    sel = 1'b0;
    push_stream(0);
    run_sweep(1'b0, 1'b0, 1'b0, 1'b1, 1025);

    // Reset while beat 50 is presented
    for (int i = 0; i < 50; i++) exp_q.push_back({i[7:0], pat_val(0, i), 1'b0});
    clear_en = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(posedge clk); #1;
      if (mv && ma == 8'd50) found = 1'b1;
    end
    out_ready = 1'b0;
    check_eq("reach_addr50", int'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset_mid_sweep");
    check_eq("queue_at_reset", exp_q.size(), 0);
    check_mem("mem_partial_clear", 1'b0, 3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_stream(3);
    run_sweep(1'b0, 1'b0, 1'b0, 1'b0, 1025);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
